// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl -- instruction fetch controller with a small registered queue.
//
// Fetches 32-bit words from a combinationally read ROM at fetch_pc, queues
// {instr, pc} pairs and presents the queue head to the core through a
// valid/ready handshake. Redirects flush the queue and restart fetch;
// misaligned redirects and fetches beyond the ROM halt the fetcher with
// fetch_fault raised until an aligned, in-range redirect arrives.
//
// Configuration macro:
//   FETCH_PREFETCH_EN  defined   -> two-entry queue (fetch runs ahead)
//                      undefined -> one-entry queue
//
// Parameters:
//   RESET_PC   first fetch address after reset
//   ROM_WORDS  number of 32-bit words in the ROM
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous active-high reset
//   enable          permits new ROM fetches
//   rom_addr        byte address to ROM (word index rom_addr[31:2])
//   rom_data        ROM word for rom_addr, same cycle
//   instr_valid     queue head holds an instruction
//   instr_ready     core accepts head this cycle
//   instr           head instruction word
//   instr_pc        byte address of head instruction
//   redirect_valid  one-cycle fetch restart request
//   redirect_pc     restart address
//   fetch_fault     high while halted on a fault
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

`ifdef FETCH_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif

    // One past the last valid byte address; 33 bits so large ROMs cannot wrap.
    localparam logic [32:0] PC_LIMIT = 33'(ROM_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;

    // Queue: head slot drives the outputs directly; tail slot only fills
    // when the two-entry configuration is built.
    logic        head_valid;
    logic [31:0] head_instr;
    logic [31:0] head_pc;
    logic        tail_valid;
    logic [31:0] tail_instr;
    logic [31:0] tail_pc;

    logic pop;
    logic slot_free;
    logic fetch_try;
    logic fetch_in_range;
    logic push;
    logic fetch_oob;
    logic redirect_aligned;
    logic redirect_in_range;

    // Handshake and fetch qualification
    always_comb begin
        pop               = head_valid & instr_ready;
        // A popping head frees a slot in the same cycle, even when full.
        slot_free         = (DEPTH == 32'd2) ? (~tail_valid | pop) : (~head_valid | pop);
        fetch_try         = (state == RUN) & enable & ~redirect_valid & slot_free;
        fetch_in_range    = ({1'b0, fetch_pc} < PC_LIMIT);
        push              = fetch_try & fetch_in_range;
        fetch_oob         = fetch_try & ~fetch_in_range;
        redirect_aligned  = (redirect_pc[1:0] == 2'b00);
        redirect_in_range = ({1'b0, redirect_pc} < PC_LIMIT);
    end

    // State, fetch pointer and queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            fetch_fault <= 1'b0;
            head_valid  <= 1'b0;
            head_instr  <= 32'd0;
            head_pc     <= 32'd0;
            tail_valid  <= 1'b0;
            tail_instr  <= 32'd0;
            tail_pc     <= 32'd0;
        end else if (redirect_valid) begin
            // Redirect overrides push and pop: everything queued is discarded.
            head_valid <= 1'b0;
            tail_valid <= 1'b0;
            if (!redirect_aligned) begin
                state       <= HALT;
                fetch_fault <= 1'b1;
            end else begin
                fetch_pc <= redirect_pc;
                if (state == HALT) begin
                    // Only a target inside the ROM releases the halt.
                    if (redirect_in_range) begin
                        state       <= RUN;
                        fetch_fault <= 1'b0;
                    end
                end else begin
                    state <= enable ? RUN : IDLE;
                end
            end
        end else begin
            // Queue movement; pop is applied before push.
            unique case ({push, pop})
                2'b10: begin
                    if (!head_valid) begin
                        head_valid <= 1'b1;
                        head_instr <= rom_data;
                        head_pc    <= fetch_pc;
                    end else begin
                        tail_valid <= 1'b1;
                        tail_instr <= rom_data;
                        tail_pc    <= fetch_pc;
                    end
                end
                2'b01: begin
                    head_valid <= tail_valid;
                    tail_valid <= 1'b0;
                    if (tail_valid) begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                    end
                end
                2'b11: begin
                    // Occupancy unchanged: shift tail forward if present.
                    if (tail_valid) begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                        tail_instr <= rom_data;
                        tail_pc    <= fetch_pc;
                    end else begin
                        head_instr <= rom_data;
                        head_pc    <= fetch_pc;
                    end
                end
                default: begin
                end
            endcase

            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (fetch_oob) begin
                        state       <= HALT;
                        fetch_fault <= 1'b1;
                    end
                end
                HALT: begin
                end
                default: begin
                    state       <= IDLE;
                    fetch_fault <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr    = fetch_pc;
    assign instr_valid = head_valid;
    assign instr       = head_instr;
    assign instr_pc    = head_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl -- scoreboard bench for fetch_ctrl.
// A reference model updates an expected queue on each clock; a monitor
// compares DUT outputs with the expected queue head every cycle and retires
// entries on handshakes. Directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam int unsigned ROM_WORDS = 256;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned LIMIT     = ROM_WORDS * 4;
`ifdef FETCH_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        fetch_fault;

    logic [31:0] rom [0:255];

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] mpc = RESET_PC;
    int          mmode = M_IDLE;

    fetch_ctrl #(
        .RESET_PC (RESET_PC),
        .ROM_WORDS(ROM_WORDS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (rom_addr < 32'(LIMIT)) rom_data = rom[rom_addr[9:2]];
        else                       rom_data = 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch rules applied to an expected queue per clock.
    initial forever begin
        ent_t e;
        @(posedge clk or posedge reset);
        if (reset) begin
            sb.delete();
            mpc   = RESET_PC;
            mmode = M_IDLE;
        end else if (redirect_valid) begin
            sb.delete();
            if (redirect_pc[1:0] != 2'b00) begin
                mmode = M_HALT;
            end else begin
                mpc = redirect_pc;
                if (mmode == M_HALT) begin
                    if (redirect_pc < 32'(LIMIT)) mmode = M_RUN;
                end else begin
                    mmode = enable ? M_RUN : M_IDLE;
                end
            end
        end else begin
            // Handshakes were already retired by the monitor.
            if (mmode == M_IDLE) begin
                if (enable) mmode = M_RUN;
            end else if (mmode == M_RUN) begin
                if (!enable) begin
                    mmode = M_IDLE;
                end else if (sb.size() < DEPTH) begin
                    if (mpc < 32'(LIMIT)) begin
                        e.word = rom[mpc[9:2]];
                        e.pc   = mpc;
                        sb.push_back(e);
                        mpc = mpc + 32'd4;
                    end else begin
                        mmode = M_HALT;
                    end
                end
            end
        end
    end

    // Monitor: compare outputs with the expected head, retire on handshake.
    initial forever begin
        @(negedge clk);
        chk("mon_valid", 32'(instr_valid), 32'(sb.size() > 0));
        chk("mon_fault", 32'(fetch_fault), 32'(mmode == M_HALT));
        chk("mon_rom_addr", rom_addr, mpc);
        if (sb.size() > 0) begin
            chk("mon_instr", instr, sb[0].word);
            chk("mon_instr_pc", instr_pc, sb[0].pc);
            if (instr_ready && !reset) void'(sb.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    // Startup from IDLE with ROM[0..2] streamed out back to back.
    task automatic basic_run();
        enable      = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk); chk("start_idle_valid", 32'(instr_valid), 32'd0);
        @(negedge clk); chk("start_run_valid", 32'(instr_valid), 32'd0);
        @(negedge clk); chk("start_a_valid", 32'(instr_valid), 32'd1);
        chk("start_a", instr, rom[0]); chk("start_a_pc", instr_pc, 32'h0);
        @(negedge clk); chk("start_b", instr, rom[1]); chk("start_b_pc", instr_pc, 32'h4);
        @(negedge clk); chk("start_c", instr, rom[2]); chk("start_c_pc", instr_pc, 32'h8);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_rom_addr", rom_addr, RESET_PC);
        step();
        reset = 1'b0;
        basic_run();

        // Stall with ready low: queue fills to its depth
        step();
        reset = 1'b1; enable = 1'b0; instr_ready = 1'b0;
        step();
        reset = 1'b0; enable = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_fetch_pc", rom_addr, (DEPTH == 2) ? 32'h8 : 32'h4);
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_instr", instr, rom[0]);
        chk("stall_instr_pc", instr_pc, 32'h0);

        // Redirect while full
        step();
        redirect_to(32'h20);
        instr_ready = 1'b1;
        @(negedge clk); chk("redir_flush_valid", 32'(instr_valid), 32'd0);
        @(negedge clk); chk("redir_pc", instr_pc, 32'h20); chk("redir_instr", instr, rom[8]);

        // Misaligned redirect halts; aligned redirect recovers
        step();
        redirect_to(32'h22);
        @(negedge clk); chk("mis_fault", 32'(fetch_fault), 32'd1); chk("mis_valid", 32'(instr_valid), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); chk("mis_hold_valid", 32'(instr_valid), 32'd0); chk("mis_hold_fault", 32'(fetch_fault), 32'd1);
        step();
        redirect_to(32'h10);
        @(negedge clk); chk("rec_fault", 32'(fetch_fault), 32'd0);
        @(negedge clk); chk("rec_valid", 32'(instr_valid), 32'd1); chk("rec_pc", instr_pc, 32'h10);

        // Last ROM word delivered, then out-of-range fault
        step();
        redirect_to(32'(LIMIT - 4));
        @(negedge clk); chk("end_flush_valid", 32'(instr_valid), 32'd0);
        @(negedge clk); chk("end_pc", instr_pc, 32'(LIMIT - 4)); chk("end_instr", instr, rom[255]);
        chk("end_fault_lo", 32'(fetch_fault), 32'd0);
        @(negedge clk); chk("end_fault_hi", 32'(fetch_fault), 32'd1); chk("end_valid", 32'(instr_valid), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); chk("end_no_fetch", 32'(instr_valid), 32'd0);

        // Asynchronous reset between edges while full
        step();
        redirect_to(32'h0);
        instr_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); chk("pre_reset_valid", 32'(instr_valid), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_rom_addr", rom_addr, RESET_PC);
        chk("async_fault", 32'(fetch_fault), 32'd0);
        #1 reset = 1'b0;
        basic_run();

        // Random traffic
        step();
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            enable      = ($urandom_range(0, 9) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            redirect_valid = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                r = $urandom_range(0, 9);
                if (r == 0)      redirect_pc = {$urandom_range(0, 255) & 32'h3FC} | 32'($urandom_range(1, 3));
                else if (r == 1) redirect_pc = 32'(LIMIT - 16) + 32'($urandom_range(0, 3) * 4);
                else if (r == 2) redirect_pc = 32'(LIMIT) + 32'($urandom_range(0, 15) * 4);
                else             redirect_pc = 32'($urandom_range(0, 255) * 4);
            end
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                #2 reset = 1'b0;
                #1;
            end else begin
                step();
            end
        end
        redirect_valid = 1'b0;
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter ROM_WORDS, default 256, number of 32-bit words in the instruction ROM.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  permits new ROM fetches when high.
REQ-006 SHALL have port rom_addr  output  32  byte address to ROM (combinational read, word index addr[31:2]).
REQ-007 SHALL have port rom_data  input  32  ROM word for rom_addr, valid same cycle.
REQ-008 SHALL have port instr_valid  output  1  queue head holds an instruction.
REQ-009 SHALL have port instr_ready  input  1  core accepts head this cycle.
REQ-010 SHALL have port instr  output  32  head instruction word.
REQ-011 SHALL have port instr_pc  output  32  byte address of head instruction.
REQ-012 SHALL have port redirect_valid  input  1  one-cycle request to restart fetch (branch/jump).
REQ-013 SHALL have port redirect_pc  input  32  new fetch address.
REQ-014 SHALL have port fetch_fault  output  1  high while halted on a fault.

Function
REQ-015 SHALL implement states IDLE, RUN, HALT; IDLE->RUN when enable=1; RUN->IDLE when enable=0 (queue retained); RUN->HALT on fault; HALT->RUN only on an aligned, in-range redirect.
REQ-016 SHALL keep register fetch_pc; rom_addr SHALL equal fetch_pc at all times.
REQ-017 In RUN with queue not full (or full with instr_ready=1), SHALL push {rom_data, fetch_pc} at the clock edge and set fetch_pc <= fetch_pc+4 (mod 2^32).
REQ-018 instr_valid, instr, instr_pc SHALL be driven from registered queue head; first instr_valid one cycle after first RUN fetch cycle.
REQ-019 Pop SHALL occur on edge where instr_valid=1 and instr_ready=1; simultaneous push and pop SHALL keep occupancy unchanged, including when full.
REQ-020 instr and instr_pc SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-021 redirect_valid SHALL take priority over push and pop: queue flushed, fetch_pc <= redirect_pc, no push that cycle; instr_valid=0 next cycle.
REQ-022 Redirect with redirect_pc[1:0]!=0 SHALL flush, enter HALT, assert fetch_fault; fetch_pc unchanged.
REQ-023 A fetch with fetch_pc >= ROM_WORDS*4 SHALL not push; SHALL enter HALT and assert fetch_fault; entries already queued remain poppable.
REQ-024 fetch_fault SHALL be high exactly while in HALT.

Reset
REQ-025 On reset: state=IDLE, fetch_pc=RESET_PC, queue empty, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0, rom_addr=RESET_PC.
REQ-026 Reset asserted mid-operation SHALL discard queue contents immediately, independent of clk.

Configuration
REQ-027 Macro FETCH_PREFETCH_EN defined: queue depth 2; fetch continues while any slot free or head popping.
REQ-028 Macro FETCH_PREFETCH_EN undefined: queue depth 1; fetch only when empty or head popping same cycle; all other rules unchanged.

Verification
REQ-029 Reset, enable=1, instr_ready=1, ROM[0..2]=A,B,C -> instr_valid rises one cycle after first RUN cycle; A@0, B@4, C@8 on consecutive cycles.
REQ-030 instr_ready=0 for 5 cycles -> with macro: 2 entries held, fetch_pc=8, A@0 stable; without: 1 entry, fetch_pc=4.
REQ-031 redirect_valid=1, redirect_pc=0x20 while queue full -> next cycle instr_valid=0; next accepted instr_pc=0x20 with ROM[8].
REQ-032 redirect_pc=0x22 -> HALT, fetch_fault=1, no pushes; later redirect_pc=0x10 -> fetch_fault=0, instr_pc=0x10 delivered.
REQ-033 redirect_pc=ROM_WORDS*4-4=0x3FC -> word at 0x3FC delivered, then fetch_fault=1, no fetch at 0x400.
REQ-034 reset pulsed between clock edges while queue full -> instr_valid=0 immediately, fetch_pc=RESET_PC, restart identical to REQ-029.
